// File: rtl/spi_data_pkg.sv
// Shared constants for the SPI data buffer: status word layout and default widths.
package spi_data_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int BUS_W_DEF  = 32;
    localparam int DEPTH_DEF  = 8;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVF   = 5;
    localparam int ST_TX_UDF   = 6;
    localparam int ST_RX_UDF   = 7;

    localparam int ST_TXCNT_LSB = 8;
    localparam int ST_RXCNT_LSB = 16;
    localparam int ST_CNT_W     = 8;

endpackage

// File: rtl/spi_sync_fifo.sv
// First-word-fall-through synchronous FIFO with overflow/underflow event pulses.
module spi_sync_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf_evt,
    output logic          udf_evt
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;
    logic          flush;

    assign flush = rst || clr;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign count = count_reg;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts the pair.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign ovf_evt = push && !do_push && !flush;
    assign udf_evt = pop && empty && !flush;

    assign dout = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spi_data_fifo_reg.sv
// Bus-side data buffer for the SPI engine: TX and RX FIFOs plus a status word with sticky errors.
module spi_data_fifo_reg
    import spi_data_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BUS_W  = BUS_W_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              bus_wr,
    input  logic [BUS_W-1:0]  bus_wdata,
    input  logic              bus_rd,
    output logic [BUS_W-1:0]  bus_rdata,
    output logic [BUS_W-1:0]  status,
    output logic              spi_tx_valid,
    output logic [DATA_W-1:0] spi_tx_data,
    input  logic              spi_tx_pop,
    input  logic              spi_rx_push,
    input  logic [DATA_W-1:0] spi_rx_data
);

    logic              tx_empty;
    logic              tx_full;
    logic [AW:0]       tx_count;
    logic              tx_ovf_evt;
    logic              tx_udf_evt;
    logic              rx_empty;
    logic              rx_full;
    logic [AW:0]       rx_count;
    logic              rx_ovf_evt;
    logic              rx_udf_evt;
    logic [DATA_W-1:0] rx_dout;

    logic              tx_ovf_reg;
    logic              rx_ovf_reg;
    logic              tx_udf_reg;
    logic              rx_udf_reg;

    spi_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (bus_wr),
        .din     (bus_wdata[DATA_W-1:0]),
        .pop     (spi_tx_pop),
        .dout    (spi_tx_data),
        .empty   (tx_empty),
        .full    (tx_full),
        .count   (tx_count),
        .ovf_evt (tx_ovf_evt),
        .udf_evt (tx_udf_evt)
    );

    spi_sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .push    (spi_rx_push),
        .din     (spi_rx_data),
        .pop     (bus_rd),
        .dout    (rx_dout),
        .empty   (rx_empty),
        .full    (rx_full),
        .count   (rx_count),
        .ovf_evt (rx_ovf_evt),
        .udf_evt (rx_udf_evt)
    );

    // Only the low DATA_W bits of a bus write reach the FIFO.
    generate
        if (BUS_W > DATA_W) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus_wdata[BUS_W-1:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tx_ovf_reg <= 1'b0;
            rx_ovf_reg <= 1'b0;
            tx_udf_reg <= 1'b0;
            rx_udf_reg <= 1'b0;
        end else begin
            tx_ovf_reg <= tx_ovf_reg | tx_ovf_evt;
            rx_ovf_reg <= rx_ovf_reg | rx_ovf_evt;
            tx_udf_reg <= tx_udf_reg | tx_udf_evt;
            rx_udf_reg <= rx_udf_reg | rx_udf_evt;
        end
    end

    assign spi_tx_valid = !tx_empty;

    always_comb begin
        bus_rdata               = '0;
        bus_rdata[DATA_W-1:0]   = rx_dout;
    end

    always_comb begin
        status                              = '0;
        status[ST_TX_EMPTY]                 = tx_empty;
        status[ST_TX_FULL]                  = tx_full;
        status[ST_RX_EMPTY]                 = rx_empty;
        status[ST_RX_FULL]                  = rx_full;
        status[ST_TX_OVF]                   = tx_ovf_reg;
        status[ST_RX_OVF]                   = rx_ovf_reg;
        status[ST_TX_UDF]                   = tx_udf_reg;
        status[ST_RX_UDF]                   = rx_udf_reg;
        status[ST_TXCNT_LSB +: ST_CNT_W]    = ST_CNT_W'(tx_count);
        status[ST_RXCNT_LSB +: ST_CNT_W]    = ST_CNT_W'(rx_count);
    end

endmodule

// File: tb/tb_spi_data_fifo_reg.sv
// Scoreboard bench for spi_data_fifo_reg: directed test-plan sequences followed by randomized traffic.
module tb_spi_data_fifo_reg;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;
    localparam int BUS_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              bus_wr = 1'b0;
    logic [BUS_W-1:0]  bus_wdata = '0;
    logic              bus_rd = 1'b0;
    logic [BUS_W-1:0]  bus_rdata;
    logic [BUS_W-1:0]  status;
    logic              spi_tx_valid;
    logic [DATA_W-1:0] spi_tx_data;
    logic              spi_tx_pop = 1'b0;
    logic              spi_rx_push = 1'b0;
    logic [DATA_W-1:0] spi_rx_data = '0;

    always #5 clk = ~clk;

    spi_data_fifo_reg #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .BUS_W  (BUS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .bus_wr       (bus_wr),
        .bus_wdata    (bus_wdata),
        .bus_rd       (bus_rd),
        .bus_rdata    (bus_rdata),
        .status       (status),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_pop   (spi_tx_pop),
        .spi_rx_push  (spi_rx_push),
        .spi_rx_data  (spi_rx_data)
    );

    typedef struct packed {
        logic [31:0] status;
        logic        tx_valid;
        logic [11:0] tx_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_tx[$];
    logic [11:0] m_rx[$];
    bit          m_tx_ovf, m_rx_ovf, m_tx_udf, m_rx_udf;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_txn = 0;

    function automatic exp_t model_snapshot();
        exp_t e;
        e.status = {8'h00, 8'(m_rx.size()), 8'(m_tx.size()),
                    m_rx_udf, m_tx_udf, m_rx_ovf, m_tx_ovf,
                    (m_rx.size() == DEPTH), (m_rx.size() == 0),
                    (m_tx.size() == DEPTH), (m_tx.size() == 0)};
        e.tx_valid = (m_tx.size() != 0);
        e.tx_data  = (m_tx.size() != 0) ? m_tx[0] : 12'h000;
        e.rdata    = (m_rx.size() != 0) ? {20'h0, m_rx[0]} : 32'h0;
        return e;
    endfunction

    // Reference behaviour: a FIFO is a bounded queue; a pop needs data, a push needs room
    // unless a successful pop happens in the same cycle.
    task automatic model_step(input bit r, input bit c, input bit wr, input logic [11:0] wd,
                              input bit rd, input bit tp, input bit rp, input logic [11:0] rdat);
        bit pop_ok;
        bit push_ok;
        if (r || c) begin
            m_tx.delete();
            m_rx.delete();
            m_tx_ovf = 0; m_rx_ovf = 0; m_tx_udf = 0; m_rx_udf = 0;
        end else begin
            pop_ok  = tp && (m_tx.size() > 0);
            push_ok = wr && ((m_tx.size() < DEPTH) || pop_ok);
            if (tp && m_tx.size() == 0) m_tx_udf = 1;
            if (wr && !push_ok) m_tx_ovf = 1;
            if (pop_ok) void'(m_tx.pop_front());
            if (push_ok) m_tx.push_back(wd);

            pop_ok  = rd && (m_rx.size() > 0);
            push_ok = rp && ((m_rx.size() < DEPTH) || pop_ok);
            if (rd && m_rx.size() == 0) m_rx_udf = 1;
            if (rp && !push_ok) m_rx_ovf = 1;
            if (pop_ok) void'(m_rx.pop_front());
            if (push_ok) m_rx.push_back(rdat);
        end
    endtask

    task automatic step(input bit r, input bit c, input bit wr, input logic [31:0] wd,
                        input bit rd, input bit tp, input bit rp, input logic [11:0] rdat);
        @(negedge clk);
        rst = r; clr = c; bus_wr = wr; bus_wdata = wd;
        bus_rd = rd; spi_tx_pop = tp; spi_rx_push = rp; spi_rx_data = rdat;
        model_step(r, c, wr, wd[11:0], rd, tp, rp, rdat);
        exp_q.push_back(model_snapshot());
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 0, 0, 12'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: after every active edge the DUT presents a new state; compare it to the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: status=%08h tx_valid=%b tx_data=%03h rdata=%08h",
                     n_txn, status, spi_tx_valid, spi_tx_data, bus_rdata);
            chk("status", status, e.status);
            chk("spi_tx_valid", {31'h0, spi_tx_valid}, {31'h0, e.tx_valid});
            chk("spi_tx_data", {20'h0, spi_tx_data}, {20'h0, e.tx_data});
            chk("bus_rdata", bus_rdata, e.rdata);
        end
    end

    initial begin
        int p_a;
        int p_b;
        // 1. reset, then first write visible next cycle
        step(1, 0, 0, 32'h0, 0, 0, 0, 12'h0);
        step(1, 0, 0, 32'h0, 0, 0, 0, 12'h0);
        step(0, 0, 1, 32'hFFFF_F123, 0, 0, 0, 12'h0);
        step(0, 0, 0, 32'h0, 0, 1, 0, 12'h0);

        // 2. TX fill, overflow, drain, then one extra pop for underflow
        for (int i = 1; i <= 9; i++) step(0, 0, 1, 32'(i), 0, 0, 0, 12'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 0, 1, 0, 12'h0);
        step(0, 0, 0, 32'h0, 0, 1, 0, 12'h0);

        // 3. RX pointer wrap
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 0, 0, 1, 12'($urandom));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1, 0, 0, 12'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 0, 0, 1, 12'hA00 + 12'(i));
        for (int i = 0; i < 7; i++) step(0, 0, 0, 32'h0, 1, 0, 0, 12'h0);

        // 4. simultaneous push/pop on full and on empty RX
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 0, 0, 1, 12'h100 + 12'(i));
        step(0, 0, 0, 32'h0, 1, 0, 1, 12'h7FF);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 32'h0, 1, 0, 0, 12'h0);
        step(0, 1, 0, 32'h0, 0, 0, 0, 12'h0);
        step(0, 0, 0, 32'h0, 1, 0, 1, 12'h3C3);
        step(0, 0, 0, 32'h0, 1, 0, 0, 12'h0);

        // 5. clr mid-operation with a coincident write
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h50 + 32'(i), 0, 0, 0, 12'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0, 0, 1, 12'h60 + 12'(i));
        step(0, 0, 0, 32'h0, 0, 1, 0, 12'h0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 32'h70, 0, 0, 0, 12'h0);
        step(0, 1, 1, 32'hABC, 0, 0, 0, 12'h0);
        idle();

        // 6. all four TX/RX events in one cycle on non-empty FIFOs
        for (int i = 0; i < 2; i++) step(0, 0, 1, 32'h200 + 32'(i), 0, 0, 1, 12'h300 + 12'(i));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h210 + 32'(i), 1, 1, 1, 12'h310 + 12'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1, 1, 0, 12'h0);

        // randomized traffic with shifting fill/drain bias
        for (int blk = 0; blk < 4; blk++) begin
            p_a = (blk % 2 == 0) ? 70 : 30;
            p_b = 100 - p_a;
            for (int i = 0; i < 150; i++) begin
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 99) < p_a), $urandom,
                     ($urandom_range(0, 99) < p_b), ($urandom_range(0, 99) < p_b),
                     ($urandom_range(0, 99) < p_a), 12'($urandom));
            end
        end

        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
